// File: rtl/pmic_i2c_pkg.sv
// ---------------------------------------------------------------------------
// pmic_i2c_pkg : EFB I2C1 register map, command bytes and sequencer states.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pmic_i2c_pkg;

  localparam logic [7:0] EFB_CR   = 8'h40;
  localparam logic [7:0] EFB_CMDR = 8'h41;
  localparam logic [7:0] EFB_BR0  = 8'h42;
  localparam logic [7:0] EFB_BR1  = 8'h43;
  localparam logic [7:0] EFB_TXDR = 8'h44;
  localparam logic [7:0] EFB_SR   = 8'h45;
  localparam logic [7:0] EFB_RXDR = 8'h47;

  localparam logic [7:0] CMD_STA_WR = 8'h94;
  localparam logic [7:0] CMD_WR     = 8'h14;
  localparam logic [7:0] CMD_STO    = 8'h44;
  localparam logic [7:0] CMD_RD_STO = 8'h6C;
  localparam logic [7:0] CR_ENABLE  = 8'h80;

  localparam int SR_BUSY  = 6;
  localparam int SR_RARC  = 5;
  localparam int SR_SRW   = 4;
  localparam int SR_ARBL  = 3;
  localparam int SR_TRRDY = 2;

  typedef enum logic [4:0] {
    S_RST_WAIT  = 5'd0,
    S_INIT_BR0  = 5'd1,
    S_INIT_BR1  = 5'd2,
    S_INIT_CR   = 5'd3,
    S_IDLE      = 5'd4,
    S_TX_DEVW   = 5'd5,
    S_CMD_STA   = 5'd6,
    S_WAIT_A    = 5'd7,
    S_TX_REG    = 5'd8,
    S_CMD_REG   = 5'd9,
    S_WAIT_R    = 5'd10,
    S_TX_DATA   = 5'd11,
    S_CMD_DATA  = 5'd12,
    S_WAIT_D    = 5'd13,
    S_CMD_STOP  = 5'd14,
    S_WAIT_IDLE = 5'd15,
    S_TX_DEVR   = 5'd16,
    S_CMD_RSTA  = 5'd17,
    S_WAIT_SRW  = 5'd18,
    S_CMD_RD    = 5'd19,
    S_WAIT_RD   = 5'd20,
    S_RD_RXDR   = 5'd21,
    S_ERR_STOP  = 5'd22,
    S_ERR_WAIT  = 5'd23,
    S_DONE      = 5'd24
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pmic_i2c_master.sv
// ---------------------------------------------------------------------------
// pmic_i2c_master : sequences single-byte I2C register reads/writes via EFB I2C1.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pmic_i2c_master
  import pmic_i2c_pkg::*;
#(
  parameter logic [9:0] PRESCALE   = 10'd60,
  parameter int         POLL_LIMIT = 1024,
  parameter int         RST_WAIT   = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_rw,
  input  logic [6:0] i_dev_addr,
  input  logic [7:0] i_reg_addr,
  input  logic [7:0] i_wdata,
  output logic       o_ready,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic [7:0] o_rdata,
  output logic       o_wb_begin,
  output logic       o_wb_we,
  output logic [7:0] o_wb_addr,
  output logic [7:0] o_wb_wdata,
  input  logic       i_wb_done,
  input  logic [7:0] i_wb_rdata
);

  localparam int PW = $clog2(POLL_LIMIT + 1);
  localparam int RW = $clog2(RST_WAIT + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT - 1);
  localparam logic [RW-1:0] RST_LAST  = RW'(RST_WAIT - 1);

  state_t        state;
  logic          in_flight;
  logic [PW-1:0] poll_cnt;
  logic [RW-1:0] rst_cnt;
  logic          rw_q;
  logic [6:0]    dev_q;
  logic [7:0]    reg_q;
  logic [7:0]    wdata_q;
  logic [7:0]    rx_byte;

  logic          op_valid;
  logic          op_we;
  logic [7:0]    op_addr;
  logic [7:0]    op_data;
  state_t        seq_next;
  logic          is_poll;
  logic          cond_met;
  logic          chk_rarc;

  // Each state owns one EFB access; wait states are SR reads with a pass condition.
  always_comb begin
    op_valid = 1'b1;
    op_we    = 1'b1;
    op_addr  = EFB_SR;
    op_data  = 8'h00;
    seq_next = state;
    is_poll  = 1'b0;
    cond_met = 1'b0;
    chk_rarc = 1'b0;
    case (state)
      S_INIT_BR0: begin op_addr = EFB_BR0;  op_data = PRESCALE[7:0];          seq_next = S_INIT_BR1; end
      S_INIT_BR1: begin op_addr = EFB_BR1;  op_data = {6'b0, PRESCALE[9:8]};  seq_next = S_INIT_CR;  end
      S_INIT_CR:  begin op_addr = EFB_CR;   op_data = CR_ENABLE;              seq_next = S_IDLE;     end
      S_TX_DEVW:  begin op_addr = EFB_TXDR; op_data = {dev_q, 1'b0};          seq_next = S_CMD_STA;  end
      S_CMD_STA:  begin op_addr = EFB_CMDR; op_data = CMD_STA_WR;             seq_next = S_WAIT_A;   end
      S_TX_REG:   begin op_addr = EFB_TXDR; op_data = reg_q;                  seq_next = S_CMD_REG;  end
      S_CMD_REG:  begin op_addr = EFB_CMDR; op_data = CMD_WR;                 seq_next = S_WAIT_R;   end
      S_TX_DATA:  begin op_addr = EFB_TXDR; op_data = wdata_q;                seq_next = S_CMD_DATA; end
      S_CMD_DATA: begin op_addr = EFB_CMDR; op_data = CMD_WR;                 seq_next = S_WAIT_D;   end
      S_CMD_STOP: begin op_addr = EFB_CMDR; op_data = CMD_STO;                seq_next = S_WAIT_IDLE; end
      S_TX_DEVR:  begin op_addr = EFB_TXDR; op_data = {dev_q, 1'b1};          seq_next = S_CMD_RSTA; end
      S_CMD_RSTA: begin op_addr = EFB_CMDR; op_data = CMD_STA_WR;             seq_next = S_WAIT_SRW; end
      S_CMD_RD:   begin op_addr = EFB_CMDR; op_data = CMD_RD_STO;             seq_next = S_WAIT_RD;  end
      S_ERR_STOP: begin op_addr = EFB_CMDR; op_data = CMD_STO;                seq_next = S_ERR_WAIT; end
      S_RD_RXDR:  begin op_we = 1'b0; op_addr = EFB_RXDR;                     seq_next = S_WAIT_IDLE; end
      S_WAIT_A, S_WAIT_R, S_WAIT_D: begin
        op_we    = 1'b0;
        is_poll  = 1'b1;
        cond_met = i_wb_rdata[SR_TRRDY];
        chk_rarc = 1'b1;
        seq_next = (state == S_WAIT_A) ? S_TX_REG :
                   (state == S_WAIT_D) ? S_CMD_STOP :
                   (rw_q ? S_TX_DEVR : S_TX_DATA);
      end
      S_WAIT_SRW: begin
        op_we = 1'b0; is_poll = 1'b1; cond_met = i_wb_rdata[SR_SRW]; chk_rarc = 1'b1; seq_next = S_CMD_RD;
      end
      S_WAIT_RD: begin
        op_we = 1'b0; is_poll = 1'b1; cond_met = i_wb_rdata[SR_TRRDY]; seq_next = S_RD_RXDR;
      end
      S_WAIT_IDLE, S_ERR_WAIT: begin
        op_we = 1'b0; is_poll = 1'b1; cond_met = ~i_wb_rdata[SR_BUSY]; seq_next = S_DONE;
      end
      default: begin
        op_valid = 1'b0;
        op_we    = 1'b0;
      end
    endcase
  end

  logic   poll_fin;
  logic   poll_err;
  logic   poll_retry;
  state_t poll_state;

  always_comb begin
    poll_fin   = 1'b0;
    poll_err   = 1'b0;
    poll_retry = 1'b0;
    poll_state = seq_next;
    if (i_wb_rdata[SR_ARBL]) begin
      // Bus is no longer ours, so no stop is issued.
      poll_fin = 1'b1;
      poll_err = 1'b1;
    end else if (cond_met) begin
      if (chk_rarc && i_wb_rdata[SR_RARC]) begin
        poll_state = S_ERR_STOP;
      end else if (seq_next == S_DONE) begin
        poll_fin = 1'b1;
        poll_err = (state == S_ERR_WAIT);
      end
    end else if (poll_cnt == POLL_LAST) begin
      if (state == S_ERR_WAIT) begin
        poll_fin = 1'b1;
        poll_err = 1'b1;
      end else begin
        poll_state = S_ERR_STOP;
      end
    end else begin
      poll_retry = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= S_RST_WAIT;
      in_flight  <= 1'b0;
      poll_cnt   <= '0;
      rst_cnt    <= '0;
      rw_q       <= 1'b0;
      dev_q      <= 7'h00;
      reg_q      <= 8'h00;
      wdata_q    <= 8'h00;
      rx_byte    <= 8'h00;
      o_ready    <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      o_rdata    <= 8'h00;
      o_wb_begin <= 1'b0;
      o_wb_we    <= 1'b0;
      o_wb_addr  <= 8'h00;
      o_wb_wdata <= 8'h00;
    end else begin
      o_wb_begin <= 1'b0;
      o_done     <= 1'b0;
      case (state)
        // The handler has no reset; any done seen here belongs to a stale access.
        S_RST_WAIT: begin
          if (rst_cnt == RST_LAST) state <= S_INIT_BR0;
          else                     rst_cnt <= rst_cnt + 1'b1;
        end
        S_IDLE: begin
          if (i_start && o_ready && !o_busy) begin
            rw_q    <= i_rw;
            dev_q   <= i_dev_addr;
            reg_q   <= i_reg_addr;
            wdata_q <= i_wdata;
            o_err   <= 1'b0;
            o_busy  <= 1'b1;
            state   <= S_TX_DEVW;
          end
        end
        S_DONE: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          if (!in_flight) begin
            if (op_valid) begin
              o_wb_begin <= 1'b1;
              o_wb_we    <= op_we;
              o_wb_addr  <= op_addr;
              o_wb_wdata <= op_data;
              in_flight  <= 1'b1;
            end
          end else if (i_wb_done) begin
            in_flight <= 1'b0;
            poll_cnt  <= '0;
            if (!is_poll) begin
              state <= seq_next;
              if (state == S_INIT_CR) o_ready <= 1'b1;
              if (state == S_RD_RXDR) rx_byte <= i_wb_rdata;
            end else if (poll_fin) begin
              o_done <= 1'b1;
              o_err  <= poll_err;
              state  <= S_DONE;
              if (!poll_err && rw_q) o_rdata <= rx_byte;
            end else if (poll_retry) begin
              poll_cnt <= poll_cnt + 1'b1;
            end else begin
              state <= poll_state;
            end
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pmic_i2c_master.sv
// ---------------------------------------------------------------------------
// tb_pmic_i2c_master : EFB/wishbone handler model with write and result scoreboards.
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_pmic_i2c_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] dev = 7'h00;
  logic [7:0] reg_a = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic       ready, busy, done, err;
  logic [7:0] rdata;
  logic       wb_begin, wb_we;
  logic [7:0] wb_addr, wb_wdata;
  logic       wb_done = 1'b0;
  logic [7:0] wb_rdata = 8'h00;

  always #5 clk = ~clk;

  pmic_i2c_master #(.PRESCALE(10'd60), .POLL_LIMIT(8), .RST_WAIT(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_rw(rw),
    .i_dev_addr(dev), .i_reg_addr(reg_a), .i_wdata(wdata),
    .o_ready(ready), .o_busy(busy), .o_done(done), .o_err(err), .o_rdata(rdata),
    .o_wb_begin(wb_begin), .o_wb_we(wb_we), .o_wb_addr(wb_addr), .o_wb_wdata(wb_wdata),
    .i_wb_done(wb_done), .i_wb_rdata(wb_rdata)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [15:0] exp_wr[$];
  logic [8:0]  exp_res[$];
  logic [7:0]  sr_val = 8'h14;
  logic [7:0]  rxdr_val = 8'h00;
  int          sr_reads = 0;
  int          wr_count = 0;
  bit          mon_en = 1'b0;
  bit          inject = 1'b0;
  bit          pend = 1'b0;
  int          lat = 0;
  logic [7:0]  cur_addr = 8'h00;
  logic [15:0] e_wr;

  // Handler model: done two cycles after begin; writes checked against the scoreboard.
  always @(negedge clk) begin
    wb_done = 1'b0;
    if (inject) begin
      wb_done  = 1'b1;
      wb_rdata = 8'hFF;
      inject   = 1'b0;
    end else if (pend) begin
      if (lat == 0) begin
        wb_done  = 1'b1;
        pend     = 1'b0;
        wb_rdata = (cur_addr == 8'h45) ? sr_val : (cur_addr == 8'h47) ? rxdr_val : 8'h00;
      end else begin
        lat--;
      end
    end else if (wb_begin) begin
      pend     = 1'b1;
      lat      = 1;
      cur_addr = wb_addr;
      if (mon_en) begin
        if (wb_we) begin
          wr_count++;
          e_wr = (exp_wr.size() > 0) ? exp_wr.pop_front() : 16'hDEAD;
          check("wb_wr", {16'h0, wb_addr, wb_wdata}, {16'h0, e_wr});
        end else if (wb_addr == 8'h45) begin
          sr_reads++;
        end
      end
    end
  end

  task automatic push_w(input logic [7:0] a, input logic [7:0] d);
    exp_wr.push_back({a, d});
  endtask

  task automatic push_init();
    push_w(8'h42, 8'h3C); push_w(8'h43, 8'h00); push_w(8'h40, 8'h80);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 500 && !ready; i++) @(negedge clk);
    check("ready", ready, 1);
    check("init_left", exp_wr.size(), 0);
  endtask

  task automatic run_txn(input logic r, input logic [6:0] d, input logic [7:0] ra,
                         input logic [7:0] wd, input logic e_err, input logic [7:0] e_rd,
                         input bit poke);
    logic [8:0] res;
    @(negedge clk);
    start = 1'b1; rw = r; dev = d; reg_a = ra; wdata = wd;
    exp_res.push_back({e_err, e_rd});
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", busy, 1);
    rw = ~r; dev = 7'h7F; reg_a = 8'hEE; wdata = 8'hEE;
    for (int i = 0; i < 3000 && !done; i++) begin
      start = poke && (i < 5);
      @(negedge clk);
    end
    start = 1'b0;
    check("done_seen", done, 1);
    res = exp_res.pop_front();
    check("err", err, res[8]);
    check("rdata", rdata, res[7:0]);
    check("busy_at_done", busy, 1);
    check("wr_left", exp_wr.size(), 0);
    @(negedge clk);
    check("done_fall", {done, busy}, 0);
  endtask

  initial begin
    // Reset and init
    repeat (4) @(negedge clk);
    check("rst_out", {ready, busy, done, err, wb_begin, wb_we, wb_addr, rdata}, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    push_init();
    wait_ready();

    // Write dev 0x48 reg 0x10 data 0xA5
    sr_val = 8'h14;
    push_w(8'h44, 8'h90); push_w(8'h41, 8'h94); push_w(8'h44, 8'h10); push_w(8'h41, 8'h14);
    push_w(8'h44, 8'hA5); push_w(8'h41, 8'h14); push_w(8'h41, 8'h44);
    run_txn(1'b0, 7'h48, 8'h10, 8'hA5, 1'b0, 8'h00, 1'b0);

    // Read dev 0x48 reg 0x02 -> 0x5A
    rxdr_val = 8'h5A;
    push_w(8'h44, 8'h90); push_w(8'h41, 8'h94); push_w(8'h44, 8'h02); push_w(8'h41, 8'h14);
    push_w(8'h44, 8'h91); push_w(8'h41, 8'h94); push_w(8'h41, 8'h6C);
    run_txn(1'b1, 7'h48, 8'h02, 8'h00, 1'b0, 8'h5A, 1'b0);

    // NACK on address byte
    sr_val = 8'h34;
    push_w(8'h44, 8'h90); push_w(8'h41, 8'h94); push_w(8'h41, 8'h44);
    run_txn(1'b0, 7'h48, 8'h10, 8'h11, 1'b1, 8'h5A, 1'b0);

    // TRRDY never set: timeout after POLL_LIMIT polls, start pokes while busy
    sr_val = 8'h00;
    sr_reads = 0;
    push_w(8'h44, 8'h90); push_w(8'h41, 8'h94); push_w(8'h41, 8'h44);
    run_txn(1'b1, 7'h48, 8'h02, 8'h00, 1'b1, 8'h5A, 1'b1);
    check("sr_reads", sr_reads, 9);

    // Arbitration lost: immediate error, no stop
    sr_val = 8'h1C;
    push_w(8'h44, 8'h90); push_w(8'h41, 8'h94);
    run_txn(1'b0, 7'h48, 8'h33, 8'h44, 1'b1, 8'h5A, 1'b0);

    // Reset in the middle of a read, stale done during the reset wait
    sr_val = 8'h14;
    wr_count = 0;
    push_w(8'h44, 8'h90); push_w(8'h41, 8'h94); push_w(8'h44, 8'h02); push_w(8'h41, 8'h14);
    @(negedge clk);
    start = 1'b1; rw = 1'b1; dev = 7'h48; reg_a = 8'h02;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && wr_count < 3; i++) @(negedge clk);
    check("mid_progress", wr_count, 3);
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    rst_n = 1'b0;
    exp_wr.delete();
    repeat (3) @(negedge clk);
    check("rst_mid_out", {ready, busy, done, err, wb_begin, rdata}, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    push_init();
    repeat (4) @(negedge clk);
    inject = 1'b1;
    repeat (2) @(negedge clk);
    check("stale_ignored", {ready, wb_begin}, 0);
    wait_ready();

    // Read after re-init: dev 0x2D reg 0x07 -> 0xC3
    rxdr_val = 8'hC3;
    push_w(8'h44, 8'h5A); push_w(8'h41, 8'h94); push_w(8'h44, 8'h07); push_w(8'h41, 8'h14);
    push_w(8'h44, 8'h5B); push_w(8'h41, 8'h94); push_w(8'h41, 8'h6C);
    run_txn(1'b1, 7'h2D, 8'h07, 8'h00, 1'b0, 8'hC3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
